// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request side and a valid/ready
// result side. It holds one operation at a time. Shifts normally run
// serially at one bit per cycle.
//
// Build option: define SEQ_ALU_FAST_SHIFT_EN to replace the serial shifter
// with a single-cycle barrel shifter. In that build every operation
// completes with latency 1 and the SHIFT state is never entered.
//
// The in_ready, out_valid, result and zero outputs are driven directly
// from registers.

module seq_alu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]    XZERO    = {XLEN{1'b0}};

    // Single-cycle evaluation of every operation. In the serial build, a
    // shift reaches this function only when its amount is 0, so the
    // shift operations simply pass op_a through.
    function automatic logic [XLEN-1:0] alu_eval(
        input logic [3:0]      ctrl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (ctrl)
            OP_AND:  r = a & b;
            OP_SUB:  r = a - b;
            OP_ADD:  r = a + b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
            OP_SLL:  r = a << b[SHAMT_W-1:0];
            OP_SRL:  r = a >> b[SHAMT_W-1:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
`else
            OP_SLL:  r = a;
            OP_SRL:  r = a;
            OP_SRA:  r = a;
`endif
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            default: r = XZERO;
        endcase
        return r;
    endfunction

    // One-bit step of the serial shifter. SRA copies the working
    // register's MSB into the vacated bit.
    function automatic logic [XLEN-1:0] shift_one(
        input logic [3:0]      ctrl,
        input logic [XLEN-1:0] w
    );
        logic [XLEN-1:0] r;
        case (ctrl)
            OP_SLL:  r = {w[XLEN-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[XLEN-1:1]};
            OP_SRA:  r = {w[XLEN-1], w[XLEN-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t             state_r, state_s;
    logic [3:0]         ctrl_r, ctrl_s;
    logic [XLEN-1:0]    work_r, work_s;
    logic [SHAMT_W-1:0] cnt_r, cnt_s;
    logic [XLEN-1:0]    result_r, result_s;
    logic               zero_r, zero_s;
    logic               in_ready_r, in_ready_s;
    logic               out_valid_r, out_valid_s;
    logic [XLEN-1:0]    shifted_s;

`ifndef SEQ_ALU_FAST_SHIFT_EN
    logic               is_shift_s;
    logic [SHAMT_W-1:0] amt_s;

    // Find out whether the incoming request needs the multi-cycle serial shifter.
    always_comb begin
        amt_s      = op_b[SHAMT_W-1:0];
        is_shift_s = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    end
`endif

    // Work out the next state, the working registers and the output registers.
    always_comb begin
        state_s   = state_r;
        ctrl_s    = ctrl_r;
        work_s    = work_r;
        cnt_s     = cnt_r;
        result_s  = result_r;
        shifted_s = shift_one(ctrl_r, work_r);
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    ctrl_s = alu_ctrl;
`ifdef SEQ_ALU_FAST_SHIFT_EN
                    result_s = alu_eval(alu_ctrl, op_a, op_b);
                    state_s  = ST_DONE;
`else
                    if (is_shift_s && (amt_s != CNT_ZERO)) begin
                        work_s  = op_a;
                        cnt_s   = amt_s;
                        state_s = ST_SHIFT;
                    end else begin
                        result_s = alu_eval(alu_ctrl, op_a, op_b);
                        state_s  = ST_DONE;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_s = shifted_s;
                cnt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_s = shifted_s;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        zero_s      = (result_s == XZERO);
        in_ready_s  = (state_s == ST_IDLE);
        out_valid_s = (state_s == ST_DONE);
    end

    // Register update. Reset throws away any operation still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ctrl_r      <= 4'd0;
            work_r      <= XZERO;
            cnt_r       <= CNT_ZERO;
            result_r    <= XZERO;
            zero_r      <= 1'b1;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ctrl_r      <= ctrl_s;
            work_r      <= work_s;
            cnt_r       <= cnt_s;
            result_r    <= result_s;
            zero_r      <= zero_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu. It drives random and directed requests and checks
// the outputs every cycle against a behavioural model. Build with
// SEQ_ALU_FAST_SHIFT_EN defined to check the barrel-shifter build.

module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic chk_en  = 1'b0;

    seq_alu #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result, computed from the operation table with plain arithmetic.
    function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b[4:0]);
        case (c)
            4'd0: return a & b;
            4'd1: return a - b;
            4'd2: return a + b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return sa >>> sh;
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from acceptance until out_valid is visible.
    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
`ifdef SEQ_ALU_FAST_SHIFT_EN
        n = 0;
`endif
        if (c >= 4'd5 && c <= 4'd7 && n != 0) return n + 1;
        return 1;
    endfunction

    // Model: accepted request, remaining latency, and the last result produced.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = 32'd0;
    logic [31:0] m_pend = 32'd0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= 32'd0;
            m_left <= 0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (in_valid) begin
            if (ref_lat(alu_ctrl, op_b) == 1) begin
                m_done <= 1'b1;
                m_res  <= ref_op(alu_ctrl, op_a, op_b);
            end else begin
                m_busy <= 1'b1;
                m_pend <= ref_op(alu_ctrl, op_a, op_b);
                m_left <= ref_lat(alu_ctrl, op_b) - 1;
            end
        end
    end

    // Compare the DUT against the model on every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
            chk("in_ready",  {31'd0, in_ready},  {31'd0, !(m_busy || m_done)});
            if (!m_busy) begin
                chk("result", result, m_res);
                chk("zero",   {31'd0, zero}, {31'd0, (m_res == 32'd0)});
            end
        end
    end

    // Issue one request, wait for its result, hold out_ready low for 'hold' cycles, then consume.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = ($urandom_range(0, 1) == 1);
            alu_ctrl = 4'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
        end while (!out_valid && lat < 100);
        chk("latency", lat, exp_lat);
        chk("op_result", result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", result, exp_res);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_zero",     {31'd0, zero},     32'd1);
        chk("rst_result",   result,            32'd0);

        // Directed cases with hand-computed results.
        do_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1);
`ifdef SEQ_ALU_FAST_SHIFT_EN
        do_op(4'd7, 32'h8000_0000, 32'd4, 0, 32'hF800_0000, 1);
`else
        do_op(4'd7, 32'h8000_0000, 32'd4, 0, 32'hF800_0000, 5);
`endif
        do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 1);
        do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1);
        do_op(4'd1, 32'd5, 32'd5, 3, 32'd0, 1);
        do_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'd0, 1);
        do_op(4'd5, 32'h0000_0001, 32'd31, 0, 32'h8000_0000, ref_lat(4'd5, 32'd31));

        // Reset in the middle of a long shift (counter at 10 in the serial build).
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'd5; op_a = 32'hDEAD_BEEF; op_b = 32'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midshift_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("midshift_rst_ready", {31'd0, in_ready},  32'd1);
        chk("midshift_rst_result", result, 32'd0);

        // Random requests.
        for (int k = 0; k < 60; k++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (k % 4 == 0) b = {27'd0, 5'($urandom_range(0, 3))};
            do_op(c, a, b, $urandom_range(0, 3), ref_op(c, a, b), ref_lat(c, b));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
